// File: rtl/spi_slave_pkg.sv
// Shared encodings for the burst SPI slave register port.
// FSM states, command bit value and synchroniser depth.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam logic SPI_CMD_READ = 1'b1;
  localparam int   SYNC_DEPTH   = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-FF synchroniser for one async pin, plus
// registered rise/fall pulses aligned with the level output.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
      lvl    <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
      lvl    <= sync_q[SYNC_DEPTH-1];
      rise   <= sync_q[SYNC_DEPTH-1] & ~lvl;
      fall   <= ~sync_q[SYNC_DEPTH-1] & lvl;
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave register port: header + auto-incrementing
// data burst, oversampled into the clk domain.
module spi_slave_burst
  import spi_slave_pkg::*;
#(
  parameter int ASZ    = 7,
  parameter int DSZ    = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           spi_sck,
  input  logic           spi_mosi,
  input  logic           spi_ncs,
  output logic           spi_miso,
  output logic           spi_miso_oe,
  output logic [ASZ-1:0] addr,
  output logic [DSZ-1:0] data_out,
  input  logic [DSZ-1:0] data_in,
  output logic           wr_en,
  output logic           rd_en,
  output logic           busy
);

  localparam int CW = $clog2(DSZ);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  // nCS resets to the deselected level so reset never looks like a frame
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .nreset(nreset), .d(spi_sck),
    .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_ncs (
    .clk(clk), .nreset(nreset), .d(spi_ncs),
    .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .nreset(nreset), .d(spi_mosi),
    .lvl(mosi_lvl), .rise(mosi_rise_unused),
    .fall(mosi_fall_unused));

  state_t          state, state_nxt;
  logic            abort, cmd_done, addr_done;
  logic            word_done, shift_in;
  logic [CW-1:0]   cnt;
  logic            rnw;
  logic [DSZ-1:0]  mosi_sr, miso_sr, hold;
  logic            hold_vld;
  logic [RD_LAT-1:0] rd_pipe;

  assign busy     = ~ncs_lvl;
  assign spi_miso = miso_sr[DSZ-1];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    word_done = 1'b0;
    shift_in  = 1'b0;
    abort     = ncs_rise | (ncs_lvl & (sck_rise | sck_fall));
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (ncs_fall) state_nxt = CMD;
        CMD: if (sck_rise) begin
          state_nxt = ADDR;
          cmd_done  = 1'b1;
        end
        ADDR: if (sck_rise) begin
          shift_in = 1'b1;
          if (cnt == CW'(ASZ-1)) begin
            addr_done = 1'b1;
            state_nxt = DATA;
          end
        end
        DATA: if (sck_rise) begin
          shift_in  = 1'b1;
          word_done = (cnt == CW'(DSZ-1));
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt         <= '0;
      rnw         <= 1'b0;
      mosi_sr     <= '0;
      miso_sr     <= '0;
      hold        <= '0;
      hold_vld    <= 1'b0;
      rd_pipe     <= '0;
      addr        <= '0;
      data_out    <= '0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
      if (cmd_done) rnw <= mosi_lvl;
      if (shift_in) begin
        mosi_sr <= {mosi_sr[DSZ-2:0], mosi_lvl};
        cnt     <= cnt + CW'(1);
      end
      if (addr_done) begin
        cnt   <= '0;
        addr  <= {mosi_sr[ASZ-2:0], mosi_lvl};
        rd_en <= (rnw == SPI_CMD_READ);
      end
      if (word_done) begin
        cnt <= '0;
        if (rnw == SPI_CMD_READ) begin
          addr  <= addr + ASZ'(1);
          rd_en <= 1'b1;
        end else begin
          data_out <= {mosi_sr[DSZ-2:0], mosi_lvl};
          wr_en    <= 1'b1;
        end
      end
      // writes step the address only after the strobe
      if (wr_en) addr <= addr + ASZ'(1);
      if (rd_pipe[RD_LAT-1] && state != IDLE) begin
        hold     <= data_in;
        hold_vld <= 1'b1;
      end
      if (state == DATA && sck_fall && !abort) begin
        if (rnw == SPI_CMD_READ) spi_miso_oe <= 1'b1;
        if (hold_vld) begin
          miso_sr  <= hold;
          hold_vld <= 1'b0;
        end else begin
          miso_sr <= miso_sr << 1;
        end
      end
      if (state_nxt == IDLE) begin
        cnt         <= '0;
        miso_sr     <= '0;
        hold_vld    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: scoreboarded strobes,
// MISO word decode at RD_LAT=1 and RD_LAT=4.
module tb_spi_slave_burst;

  logic clk = 1'b0, nreset = 1'b0;
  logic sck = 1'b0, mosi = 1'b0, ncs = 1'b1;

  logic        miso1, oe1, wr1, rd1, busy1;
  logic [6:0]  addr1;
  logic [31:0] dout1, din1 = '0;

  logic        miso4, rd4;
  logic        oe4_unused, wr4_unused, busy4_unused;
  logic [6:0]  addr4;
  logic [31:0] dout4_unused, din4 = '0;

  int errors = 0, checks = 0;

  logic [38:0] exp_wr[$];
  logic [6:0]  exp_rd[$];
  logic [31:0] exp_miso[$];
  logic [31:0] wbuf[4];
  logic [38:0] mon_w;
  logic [6:0]  mon_r;
  logic [2:0]  p_v = '0;
  logic [6:0]  p_a[3];

  always #5 clk = ~clk;

  spi_slave_burst #(.ASZ(7), .DSZ(32), .RD_LAT(1)) dut (
    .clk(clk), .nreset(nreset), .spi_sck(sck),
    .spi_mosi(mosi), .spi_ncs(ncs), .spi_miso(miso1),
    .spi_miso_oe(oe1), .addr(addr1), .data_out(dout1),
    .data_in(din1), .wr_en(wr1), .rd_en(rd1),
    .busy(busy1));

  spi_slave_burst #(.ASZ(7), .DSZ(32), .RD_LAT(4)) dut4 (
    .clk(clk), .nreset(nreset), .spi_sck(sck),
    .spi_mosi(mosi), .spi_ncs(ncs), .spi_miso(miso4),
    .spi_miso_oe(oe4_unused), .addr(addr4),
    .data_out(dout4_unused), .data_in(din4),
    .wr_en(wr4_unused), .rd_en(rd4),
    .busy(busy4_unused));

  function automatic logic [31:0] regval(input logic [6:0] a);
    return 32'hA5A5_0000 | {25'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // register file model: 1-cycle and 4-cycle read latency
  always @(posedge clk) begin
    if (rd1) din1 <= regval(addr1);
    p_v    <= {p_v[1:0], rd4};
    p_a[0] <= addr4;
    p_a[1] <= p_a[0];
    p_a[2] <= p_a[1];
    if (p_v[2]) din4 <= regval(p_a[2]);
  end

  always @(negedge clk) begin
    if (nreset) begin
      if (wr1 || rd1) chk("strobe_excl", {63'd0, wr1 & rd1}, 0);
      if (wr1) begin
        if (exp_wr.size() == 0) begin
          chk("wr_expected_pending", 64'(exp_wr.size()), 1);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", addr1, mon_w[38:32]);
          chk("wr_data", dout1, mon_w[31:0]);
        end
      end
      if (rd1) begin
        if (exp_rd.size() == 0) begin
          chk("rd_expected_pending", 64'(exp_rd.size()), 1);
        end else begin
          mon_r = exp_rd.pop_front();
          chk("rd_addr", addr1, mon_r);
        end
      end
    end
  end

  task automatic drive_bit(input logic b, output logic g1,
                           output logic g4);
    mosi = b;
    repeat (9) @(posedge clk);
    #1;
    g1  = miso1;
    g4  = miso4;
    sck = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    sck = 1'b0;
  endtask

  task automatic frame(input logic rnw, input logic [6:0] base,
                       input int nwords, input int extra);
    logic g1, g4;
    logic [31:0] r1, r4, e;
    logic [6:0] a;
    r1 = '0;
    r4 = '0;
    ncs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_set", busy1, 1);
    if (rnw) exp_rd.push_back(base);
    drive_bit(rnw, g1, g4);
    for (int i = 6; i >= 0; i--) drive_bit(base[i], g1, g4);
    chk("oe_header", oe1, 0);
    for (int k = 0; k < nwords; k++) begin
      a = base + 7'(k);
      if (rnw) begin
        exp_rd.push_back(a + 7'd1);
        exp_miso.push_back(regval(a));
      end else begin
        exp_wr.push_back({a, wbuf[k]});
      end
      for (int b = 31; b >= 0; b--) begin
        drive_bit(rnw ? 1'b0 : wbuf[k][b], g1, g4);
        r1 = {r1[30:0], g1};
        r4 = {r4[30:0], g4};
      end
      if (rnw) begin
        e = exp_miso.pop_front();
        chk("miso_word", r1, e);
        chk("miso_word_lat4", r4, e);
        chk("oe_data", oe1, 1);
      end
    end
    for (int b = 31; b > 31 - extra; b--)
      drive_bit(wbuf[nwords][b], g1, g4);
    repeat (9) @(posedge clk);
    #1;
    ncs = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("busy_clr", busy1, 0);
    chk("oe_clr", oe1, 0);
    chk("miso_idle", miso1, 0);
    chk("wr_left", 64'(exp_wr.size()), 0);
    chk("rd_left", 64'(exp_rd.size()), 0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g1, g4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", miso1, 0);
    chk("rst_oe", oe1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_data", dout1, 0);
    chk("rst_wr", wr1, 0);
    chk("rst_rd", rd1, 0);
    chk("rst_busy", busy1, 0);
    nreset = 1'b1;
    repeat (5) @(posedge clk);

    wbuf[0] = 32'hDEADBEEF;
    frame(1'b0, 7'h05, 1, 0);

    wbuf[0] = 32'h1;
    wbuf[1] = 32'h2;
    wbuf[2] = 32'h3;
    frame(1'b0, 7'h7E, 3, 0);

    frame(1'b1, 7'h10, 2, 0);

    wbuf[0] = 32'h12345678;
    frame(1'b0, 7'h20, 0, 20);
    wbuf[0] = 32'hCAFEF00D;
    frame(1'b0, 7'h21, 1, 0);

    repeat (3) begin
      sck = 1'b1;
      repeat (9) @(posedge clk);
      sck = 1'b0;
      repeat (9) @(posedge clk);
    end
    #1;
    chk("idle_sck_busy", busy1, 0);

    frame(1'b1, 7'h7F, 2, 0);

    ncs = 1'b0;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, g1, g4);
    chk("busy_mid", busy1, 1);
    #3;
    nreset = 1'b0;
    #1;
    chk("arst_miso", miso1, 0);
    chk("arst_oe", oe1, 0);
    chk("arst_addr", addr1, 0);
    chk("arst_data", dout1, 0);
    chk("arst_wr", wr1, 0);
    chk("arst_rd", rd1, 0);
    chk("arst_busy", busy1, 0);
    ncs  = 1'b1;
    mosi = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (5) @(posedge clk);

    wbuf[0] = 32'h0BADCAFE;
    frame(1'b0, 7'h33, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
